// File: rtl/data_bram_scheduler_if.sv
// Port bundle for data_bram_scheduler: load stream, two burst-read requesters,
// tagged read return and the raw BRAM port signals.
interface data_bram_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
);
  logic                  ld_start;
  logic [ADDR_WIDTH-1:0] ld_base;
  logic [ADDR_WIDTH-1:0] ld_len;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  ld_busy;
  logic                  ld_done;

  logic                  rd_req0;
  logic                  rd_req1;
  logic [ADDR_WIDTH-1:0] rd_base0;
  logic [ADDR_WIDTH-1:0] rd_base1;
  logic [ADDR_WIDTH-1:0] rd_len0;
  logic [ADDR_WIDTH-1:0] rd_len1;
  logic                  rd_gnt0;
  logic                  rd_gnt1;

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_id;
  logic                  m_last;

  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_wr_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  bram_re;
  logic [ADDR_WIDTH-1:0] bram_rd_addr;
  logic [DATA_WIDTH-1:0] bram_dout;
  logic                  err_oob;

  modport master (
    output ld_start, ld_base, ld_len, s_valid, s_data,
    output rd_req0, rd_req1, rd_base0, rd_base1, rd_len0, rd_len1,
    output bram_dout,
    input  s_ready, ld_busy, ld_done, rd_gnt0, rd_gnt1,
    input  m_valid, m_data, m_id, m_last,
    input  bram_we, bram_wr_addr, bram_din, bram_re, bram_rd_addr, err_oob
  );

  modport slave (
    input  ld_start, ld_base, ld_len, s_valid, s_data,
    input  rd_req0, rd_req1, rd_base0, rd_base1, rd_len0, rd_len1,
    input  bram_dout,
    output s_ready, ld_busy, ld_done, rd_gnt0, rd_gnt1,
    output m_valid, m_data, m_id, m_last,
    output bram_we, bram_wr_addr, bram_din, bram_re, bram_rd_addr, err_oob
  );
endinterface

// File: rtl/data_bram_scheduler.sv
// Global data BRAM access controller: streamed loads on the write port, round-robin
// burst reads on the read port. Define DATA_BRAM_RAW_INTERLOCK_EN to hold off reads during loads.
module data_bram_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned MEM_SIZE   = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bram_scheduler_if.slave bus
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned SW = ADDR_WIDTH + 1;

  typedef enum logic {L_IDLE, L_RUN}   l_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(MEM_SIZE - 1)) ? '0 : a + AW'(1);
  endfunction

  // Sum taken one bit wider so base + len never aliases below MEM_SIZE
  function automatic logic crosses_end(input logic [AW-1:0] base, input logic [AW-1:0] len);
    return (SW'(base) + SW'(len)) > SW'(MEM_SIZE);
  endfunction

  l_state_t        l_state, l_next;
  logic [AW-1:0]   ld_addr, ld_addr_n;
  logic [AW-1:0]   ld_cnt, ld_cnt_n;
  logic            ld_done_q, ld_done_n;
  logic            ld_oob_c;
  logic            wr_fire;

  r_state_t        r_state, r_next;
  logic [AW-1:0]   rd_addr, rd_addr_n;
  logic [AW-1:0]   rd_cnt, rd_cnt_n;
  logic            rd_id, rd_id_n;
  logic            rr_last, rr_last_n;
  logic            gnt0_q, gnt1_q, gnt0_n, gnt1_n;
  logic            rd_oob_c;
  logic            pick;
  logic [AW-1:0]   pick_base, pick_len;
  logic            el0, el1;
  logic            rd_issue;

  logic            m_valid_q, m_id_q, m_last_q;
  logic            err_q;

`ifdef DATA_BRAM_RAW_INTERLOCK_EN
  assign el0 = bus.rd_req0 && (l_state != L_RUN);
  assign el1 = bus.rd_req1 && (l_state != L_RUN);
`else
  assign el0 = bus.rd_req0;
  assign el1 = bus.rd_req1;
`endif

  assign wr_fire  = bus.s_valid && (l_state == L_RUN);
  assign rd_issue = (r_state == R_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state   <= L_IDLE;
      ld_addr   <= '0;
      ld_cnt    <= '0;
      ld_done_q <= 1'b0;
      r_state   <= R_IDLE;
      rd_addr   <= '0;
      rd_cnt    <= '0;
      rd_id     <= 1'b0;
      rr_last   <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_id_q    <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      l_state   <= l_next;
      ld_addr   <= ld_addr_n;
      ld_cnt    <= ld_cnt_n;
      ld_done_q <= ld_done_n;
      r_state   <= r_next;
      rd_addr   <= rd_addr_n;
      rd_cnt    <= rd_cnt_n;
      rd_id     <= rd_id_n;
      rr_last   <= rr_last_n;
      gnt0_q    <= gnt0_n;
      gnt1_q    <= gnt1_n;
      m_valid_q <= rd_issue;
      m_id_q    <= rd_id;
      m_last_q  <= rd_issue && (rd_cnt == AW'(1));
      err_q     <= err_q | ld_oob_c | rd_oob_c;
    end
  end

  // Load sequencer: zero-length commands complete immediately without entering L_RUN
  always_comb begin
    l_next    = l_state;
    ld_addr_n = ld_addr;
    ld_cnt_n  = ld_cnt;
    ld_done_n = 1'b0;
    ld_oob_c  = 1'b0;
    case (l_state)
      L_IDLE: begin
        if (bus.ld_start) begin
          ld_oob_c = crosses_end(bus.ld_base, bus.ld_len);
          if (bus.ld_len != '0) begin
            l_next    = L_RUN;
            ld_addr_n = bus.ld_base;
            ld_cnt_n  = bus.ld_len;
          end else begin
            ld_done_n = 1'b1;
          end
        end
      end
      L_RUN: begin
        if (wr_fire) begin
          ld_addr_n = addr_inc(ld_addr);
          ld_cnt_n  = ld_cnt - AW'(1);
          if (ld_cnt == AW'(1)) begin
            l_next    = L_IDLE;
            ld_done_n = 1'b1;
          end
        end
      end
      default: l_next = L_IDLE;
    endcase
  end

  // Read arbiter/sequencer: no new grant while a grant pulse is still visible
  always_comb begin
    r_next    = r_state;
    rd_addr_n = rd_addr;
    rd_cnt_n  = rd_cnt;
    rd_id_n   = rd_id;
    rr_last_n = rr_last;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    rd_oob_c  = 1'b0;
    pick      = 1'b0;
    pick_base = '0;
    pick_len  = '0;
    case (r_state)
      R_IDLE: begin
        if ((el0 || el1) && !(gnt0_q || gnt1_q)) begin
          pick      = (el0 && el1) ? ~rr_last : el1;
          pick_base = pick ? bus.rd_base1 : bus.rd_base0;
          pick_len  = pick ? bus.rd_len1 : bus.rd_len0;
          gnt0_n    = ~pick;
          gnt1_n    = pick;
          rr_last_n = pick;
          rd_oob_c  = crosses_end(pick_base, pick_len);
          if (pick_len != '0) begin
            r_next    = R_BURST;
            rd_addr_n = pick_base;
            rd_cnt_n  = pick_len;
            rd_id_n   = pick;
          end
        end
      end
      R_BURST: begin
        rd_addr_n = addr_inc(rd_addr);
        rd_cnt_n  = rd_cnt - AW'(1);
        if (rd_cnt == AW'(1)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign bus.s_ready      = (l_state == L_RUN);
  assign bus.ld_busy      = (l_state == L_RUN);
  assign bus.ld_done      = ld_done_q;
  assign bus.bram_we      = wr_fire;
  assign bus.bram_wr_addr = ld_addr;
  assign bus.bram_din     = wr_fire ? bus.s_data : DATA_WIDTH'(0);
  assign bus.bram_re      = rd_issue;
  assign bus.bram_rd_addr = rd_addr;
  assign bus.rd_gnt0      = gnt0_q;
  assign bus.rd_gnt1      = gnt1_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_data       = bus.bram_dout;
  assign bus.m_id         = m_id_q;
  assign bus.m_last       = m_last_q;
  assign bus.err_oob      = err_q;

endmodule

// File: tb/tb_data_bram_scheduler.sv
// Directed self-checking bench for data_bram_scheduler with a registered-read BRAM model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_data_bram_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  data_bram_scheduler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus_if ();

  data_bram_scheduler #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(7),
    .MEM_SIZE  (100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:99];
  always @(posedge clk) begin
    if (bus_if.bram_we && bus_if.bram_wr_addr < 7'd100) mem[bus_if.bram_wr_addr] <= bus_if.bram_din;
    if (bus_if.bram_re) bus_if.bram_dout <= mem[bus_if.bram_rd_addr];
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 + 32'(a) * 32'd7;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic check_idle(input string p);
    chk({p, "_s_ready"}, bus_if.s_ready, 0);
    chk({p, "_ld_busy"}, bus_if.ld_busy, 0);
    chk({p, "_ld_done"}, bus_if.ld_done, 0);
    chk({p, "_gnt0"}, bus_if.rd_gnt0, 0);
    chk({p, "_gnt1"}, bus_if.rd_gnt1, 0);
    chk({p, "_m_valid"}, bus_if.m_valid, 0);
    chk({p, "_m_id"}, bus_if.m_id, 0);
    chk({p, "_m_last"}, bus_if.m_last, 0);
    chk({p, "_bram_we"}, bus_if.bram_we, 0);
    chk({p, "_bram_re"}, bus_if.bram_re, 0);
    chk({p, "_err_oob"}, bus_if.err_oob, 0);
    chk({p, "_wr_addr"}, bus_if.bram_wr_addr, 0);
    chk({p, "_rd_addr"}, bus_if.bram_rd_addr, 0);
    chk({p, "_bram_din"}, bus_if.bram_din, 0);
  endtask

  initial begin
    int j, ph, id, base, a;
    checks   = 0;
    failures = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus_if.ld_start = 1'b0; bus_if.ld_base = '0; bus_if.ld_len = '0;
    bus_if.s_valid  = 1'b0; bus_if.s_data  = '0;
    bus_if.rd_req0  = 1'b0; bus_if.rd_req1 = 1'b0;
    bus_if.rd_base0 = '0;   bus_if.rd_base1 = '0;
    bus_if.rd_len0  = '0;   bus_if.rd_len1  = '0;

    // Reset state
    nc(); nc();
    check_idle("reset");
    rst = 1'b0;

    // Full-memory load: base 0, len 100, s_valid held high
    bus_if.ld_start = 1'b1; bus_if.ld_base = 7'd0; bus_if.ld_len = 7'd100;
    bus_if.s_valid = 1'b1; bus_if.s_data = pat(0);
    nc();
    chk("ld_s_ready", bus_if.s_ready, 1);
    chk("ld_busy", bus_if.ld_busy, 1);
    bus_if.ld_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus_if.s_data = pat(i);
      #1;
      chk($sformatf("ld_we[%0d]", i), bus_if.bram_we, 1);
      chk($sformatf("ld_addr[%0d]", i), bus_if.bram_wr_addr, 64'(i));
      chk($sformatf("ld_din[%0d]", i), bus_if.bram_din, pat(i));
      chk($sformatf("ld_done_early[%0d]", i), bus_if.ld_done, 0);
      nc();
    end
    chk("ld_done_pulse", bus_if.ld_done, 1);
    chk("ld_s_ready_drop", bus_if.s_ready, 0);
    chk("ld_we_after", bus_if.bram_we, 0);
    bus_if.s_valid = 1'b0;
    nc();
    chk("ld_done_once", bus_if.ld_done, 0);

    // Single burst: requester 0, base 10, len 4
    bus_if.rd_req0 = 1'b1; bus_if.rd_base0 = 7'd10; bus_if.rd_len0 = 7'd4;
    for (int k = 1; k <= 6; k++) begin
      nc();
      chk($sformatf("b0_gnt0[%0d]", k), bus_if.rd_gnt0, 64'(k == 1));
      chk($sformatf("b0_gnt1[%0d]", k), bus_if.rd_gnt1, 0);
      chk($sformatf("b0_re[%0d]", k), bus_if.bram_re, 64'(k <= 4));
      if (k <= 4) chk($sformatf("b0_raddr[%0d]", k), bus_if.bram_rd_addr, 64'(10 + k - 1));
      chk($sformatf("b0_mvalid[%0d]", k), bus_if.m_valid, 64'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        chk($sformatf("b0_mdata[%0d]", k), bus_if.m_data, pat(10 + k - 2));
        chk($sformatf("b0_mid[%0d]", k), bus_if.m_id, 0);
        chk($sformatf("b0_mlast[%0d]", k), bus_if.m_last, 64'(k == 5));
      end
      if (k == 1) bus_if.rd_req0 = 1'b0;
    end

    // Round robin from a fresh pointer: both held, len 2, expect 0,1,0,1 with one bubble
    rst = 1'b1;
    nc();
    rst = 1'b0;
    bus_if.rd_req0 = 1'b1; bus_if.rd_base0 = 7'd20; bus_if.rd_len0 = 7'd2;
    bus_if.rd_req1 = 1'b1; bus_if.rd_base1 = 7'd40; bus_if.rd_len1 = 7'd2;
    for (int c = 1; c <= 13; c++) begin
      nc();
      j    = (c - 1) / 3;
      ph   = (c - 1) % 3;
      id   = j % 2;
      base = (id == 1) ? 40 : 20;
      chk($sformatf("rr_gnt0[%0d]", c), bus_if.rd_gnt0, 64'(j < 4 && ph == 0 && id == 0));
      chk($sformatf("rr_gnt1[%0d]", c), bus_if.rd_gnt1, 64'(j < 4 && ph == 0 && id == 1));
      chk($sformatf("rr_re[%0d]", c), bus_if.bram_re, 64'(j < 4 && ph != 2));
      if (j < 4 && ph != 2) chk($sformatf("rr_raddr[%0d]", c), bus_if.bram_rd_addr, 64'(base + ph));
      chk($sformatf("rr_mvalid[%0d]", c), bus_if.m_valid, 64'(ph != 0));
      if (ph != 0) begin
        chk($sformatf("rr_mid[%0d]", c), bus_if.m_id, 64'(id));
        chk($sformatf("rr_mlast[%0d]", c), bus_if.m_last, 64'(ph == 2));
        chk($sformatf("rr_mdata[%0d]", c), bus_if.m_data, pat(base + ph - 1));
      end
      if (c == 10) begin
        bus_if.rd_req0 = 1'b0;
        bus_if.rd_req1 = 1'b0;
      end
    end

    // Read request raised during a load (base 50, len 3)
    bus_if.ld_start = 1'b1; bus_if.ld_base = 7'd50; bus_if.ld_len = 7'd3;
    bus_if.s_valid = 1'b1; bus_if.s_data = pat(50);
    nc();
    chk("ml_busy", bus_if.ld_busy, 1);
    chk("ml_waddr0", bus_if.bram_wr_addr, 50);
    bus_if.ld_start = 1'b0;
    bus_if.rd_req1 = 1'b1; bus_if.rd_base1 = 7'd5; bus_if.rd_len1 = 7'd1;
    nc();
`ifdef DATA_BRAM_RAW_INTERLOCK_EN
    chk("ml_gnt1_held0", bus_if.rd_gnt1, 0);
    bus_if.s_data = pat(51);
    nc();
    chk("ml_gnt1_held1", bus_if.rd_gnt1, 0);
    bus_if.s_data = pat(52);
    nc();
    chk("ml_done", bus_if.ld_done, 1);
    chk("ml_gnt1_held2", bus_if.rd_gnt1, 0);
    bus_if.s_valid = 1'b0;
    nc();
    chk("ml_gnt1", bus_if.rd_gnt1, 1);
    chk("ml_re", bus_if.bram_re, 1);
    chk("ml_raddr", bus_if.bram_rd_addr, 5);
    bus_if.rd_req1 = 1'b0;
    nc();
    chk("ml_mvalid", bus_if.m_valid, 1);
    chk("ml_mdata", bus_if.m_data, pat(5));
    chk("ml_mid", bus_if.m_id, 1);
    chk("ml_mlast", bus_if.m_last, 1);
`else
    chk("ml_gnt1", bus_if.rd_gnt1, 1);
    chk("ml_re", bus_if.bram_re, 1);
    chk("ml_raddr", bus_if.bram_rd_addr, 5);
    chk("ml_waddr1", bus_if.bram_wr_addr, 51);
    bus_if.rd_req1 = 1'b0;
    bus_if.s_data = pat(51);
    nc();
    chk("ml_mvalid", bus_if.m_valid, 1);
    chk("ml_mdata", bus_if.m_data, pat(5));
    chk("ml_mid", bus_if.m_id, 1);
    chk("ml_mlast", bus_if.m_last, 1);
    bus_if.s_data = pat(52);
    nc();
    chk("ml_done", bus_if.ld_done, 1);
    chk("ml_busy_drop", bus_if.ld_busy, 0);
    bus_if.s_valid = 1'b0;
`endif
    nc();

    // Wrapping out-of-bound burst: base 98, len 4
    chk("oob_pre", bus_if.err_oob, 0);
    bus_if.rd_req0 = 1'b1; bus_if.rd_base0 = 7'd98; bus_if.rd_len0 = 7'd4;
    for (int k = 1; k <= 5; k++) begin
      nc();
      chk($sformatf("oob_gnt0[%0d]", k), bus_if.rd_gnt0, 64'(k == 1));
      chk($sformatf("oob_re[%0d]", k), bus_if.bram_re, 64'(k <= 4));
      a = (98 + k - 1) % 100;
      if (k <= 4) chk($sformatf("oob_raddr[%0d]", k), bus_if.bram_rd_addr, 64'(a));
      if (k >= 2) begin
        chk($sformatf("oob_mdata[%0d]", k), bus_if.m_data, pat((98 + k - 2) % 100));
        chk($sformatf("oob_mlast[%0d]", k), bus_if.m_last, 64'(k == 5));
      end
      chk($sformatf("oob_err[%0d]", k), bus_if.err_oob, 1);
      if (k == 1) bus_if.rd_req0 = 1'b0;
    end
    nc(); nc(); nc();
    chk("oob_sticky", bus_if.err_oob, 1);

    // Zero-length load and zero-length read
    bus_if.ld_start = 1'b1; bus_if.ld_base = 7'd3; bus_if.ld_len = 7'd0;
    bus_if.s_valid = 1'b1; bus_if.s_data = 32'hDEAD_BEEF;
    nc();
    chk("z_ld_done", bus_if.ld_done, 1);
    chk("z_ld_busy", bus_if.ld_busy, 0);
    chk("z_ld_we", bus_if.bram_we, 0);
    bus_if.ld_start = 1'b0; bus_if.s_valid = 1'b0;
    nc();
    chk("z_ld_done_once", bus_if.ld_done, 0);
    bus_if.rd_req1 = 1'b1; bus_if.rd_base1 = 7'd0; bus_if.rd_len1 = 7'd0;
    nc();
    chk("z_rd_gnt1", bus_if.rd_gnt1, 1);
    chk("z_rd_re", bus_if.bram_re, 0);
    bus_if.rd_req1 = 1'b0;
    nc();
    chk("z_rd_gnt1_once", bus_if.rd_gnt1, 0);
    chk("z_rd_re2", bus_if.bram_re, 0);
    chk("z_rd_mvalid", bus_if.m_valid, 0);

    // Reset in beat 2 of a len-8 burst while a len-8 load runs
    bus_if.ld_start = 1'b1; bus_if.ld_base = 7'd60; bus_if.ld_len = 7'd8;
    bus_if.s_valid = 1'b1; bus_if.s_data = pat(60);
    bus_if.rd_req0 = 1'b1; bus_if.rd_base0 = 7'd30; bus_if.rd_len0 = 7'd8;
    nc();
    chk("rs_gnt0", bus_if.rd_gnt0, 1);
    chk("rs_busy", bus_if.ld_busy, 1);
    bus_if.ld_start = 1'b0; bus_if.rd_req0 = 1'b0;
    nc();
    bus_if.s_data = pat(61);
    chk("rs_beat1_valid", bus_if.m_valid, 1);
    chk("rs_beat1_data", bus_if.m_data, pat(30));
    rst = 1'b1;
    nc();
    check_idle("midrst");
    rst = 1'b0;
    bus_if.s_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nc();
      chk($sformatf("rs_no_beat[%0d]", k), bus_if.m_valid, 0);
      chk($sformatf("rs_no_re[%0d]", k), bus_if.bram_re, 0);
    end

    // Fresh load after reset: base 0, len 2
    bus_if.ld_start = 1'b1; bus_if.ld_base = 7'd0; bus_if.ld_len = 7'd2;
    bus_if.s_valid = 1'b1; bus_if.s_data = 32'h1234_0000;
    nc();
    chk("nl_busy", bus_if.ld_busy, 1);
    chk("nl_we0", bus_if.bram_we, 1);
    chk("nl_addr0", bus_if.bram_wr_addr, 0);
    chk("nl_din0", bus_if.bram_din, 32'h1234_0000);
    bus_if.ld_start = 1'b0;
    nc();
    bus_if.s_data = 32'h1234_0001;
    #1;
    chk("nl_addr1", bus_if.bram_wr_addr, 1);
    chk("nl_din1", bus_if.bram_din, 32'h1234_0001);
    nc();
    chk("nl_done", bus_if.ld_done, 1);
    chk("nl_we_off", bus_if.bram_we, 0);
    bus_if.s_valid = 1'b0;
    nc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
